// File: rtl/pipe_ctrl.sv
// In-order pipeline backbone: per-stage stall with bubbles,
// branch flush, halt drain with sticky hlt, retire counter.
module pipe_ctrl #(
  parameter int STAGES = 5,
  parameter int WIDTH  = 16,
  parameter int FS_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_halt,
  output logic                    in_ready,
  input  logic [STAGES-1:0]       stall,
  input  logic                    flush,
  input  logic [FS_W-1:0]         flush_stage,
  output logic [STAGES-1:0]       stage_valid,
  output logic [STAGES*WIDTH-1:0] stage_data,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    hlt,
  output logic [CNT_W-1:0]        retire_cnt
);

  localparam logic [FS_W-1:0] KMAX = FS_W'(STAGES - 2);

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] tag_q, tag_d;
  logic [WIDTH-1:0]  dat_q [STAGES];
  logic [WIDTH-1:0]  dat_d [STAGES];
  logic              hlt_q, hlt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [STAGES-1:0] hold;
  logic [FS_W-1:0]   fk;
  logic              hif;
  logic              acc;

  // A stall at stage j also holds every younger stage below it
  always_comb begin
    hold = '0;
    hold[STAGES-1] = stall[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      hold[i] = hold[i+1] | stall[i];
    end
  end

  // Fetch gating, retire event and flush boundary clamp
  always_comb begin
    hif       = |(vld_q & tag_q);
    in_ready  = !hold[0] && !flush && !hif && !hlt_q;
    acc       = in_valid && in_ready;
    out_valid = vld_q[STAGES-1] && !stall[STAGES-1];
    out_data  = dat_q[STAGES-1];
    fk        = (flush_stage > KMAX) ? KMAX : flush_stage;
    hlt       = hlt_q;
    retire_cnt = cnt_q;
    stage_valid = vld_q;
    stage_data  = '0;
    for (int i = 0; i < STAGES; i++) begin
      stage_data[i*WIDTH +: WIDTH] = dat_q[i];
    end
  end

  // Next-state for the stage chain, hlt flag and counter
  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    dat_d = dat_q;
    hlt_d = hlt_q;
    cnt_d = cnt_q;
    if (out_valid) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (tag_q[STAGES-1]) hlt_d = 1'b1;
    end
    if (flush) begin
      vld_d[0] = acc;
      dat_d[0] = in_data;
      tag_d[0] = in_halt && acc;
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
      for (int i = 0; i < STAGES; i++) begin
        if (i <= int'(fk)) begin
          vld_d[i] = 1'b0;
          tag_d[i] = 1'b0;
        end
      end
    end else begin
      if (!hold[0]) begin
        vld_d[0] = acc;
        dat_d[0] = in_data;
        tag_d[0] = in_halt && acc;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (!hold[i]) begin
          if (hold[i-1]) begin
            vld_d[i] = 1'b0;
            tag_d[i] = 1'b0;
          end else begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
            tag_d[i] = tag_q[i-1];
          end
        end
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      tag_q <= '0;
      hlt_q <= 1'b0;
      cnt_q <= '0;
      for (int i = 0; i < STAGES; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      hlt_q <= hlt_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < STAGES; i++) dat_q[i] <= dat_d[i];
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, random
// stimulus against a stage-array model, directed corner cases.
module tb_pipe_ctrl;

  localparam int S = 5;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_halt;
  logic          in_ready;
  logic [S-1:0]  stall;
  logic          flush;
  logic [3:0]    flush_stage;
  logic [S-1:0]  stage_valid;
  logic [S*W-1:0] stage_data;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          hlt;
  logic [15:0]   retire_cnt;

  pipe_ctrl #(.STAGES(S), .WIDTH(W), .FS_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_halt(in_halt),
    .in_ready(in_ready), .stall(stall), .flush(flush),
    .flush_stage(flush_stage), .stage_valid(stage_valid),
    .stage_data(stage_data), .out_valid(out_valid),
    .out_data(out_data), .hlt(hlt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;

  // reference model: one slot per stage
  bit          mv [S];
  bit          mh [S];
  logic [W-1:0] md [S];
  bit          m_hlt;
  logic [15:0] m_cnt;

  // values seen before the last active edge
  logic        pr_ready, pr_ov;
  logic [W-1:0] pr_od;
  logic [S-1:0] pr_sv;

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic [S-1:0] ev;
    logic         er;
    logic         eov;
    logic [W-1:0] eod;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string nm, input logic [127:0] a,
                       input logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
    end
  endtask

  function automatic logic [W-1:0] sd(input int i);
    return stage_data[i*W +: W];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < S; i++) begin
      mv[i] = 0; mh[i] = 0; md[i] = '0;
    end
    m_hlt = 0;
    m_cnt = '0;
  endtask

  task automatic step(input logic r, input logic iv,
                      input logic [W-1:0] d, input logic ih,
                      input logic [S-1:0] st, input logic fl,
                      input logic [3:0] fs);
    int h, k;
    bit hif, erdy, eov, acc;
    logic [S-1:0] ev;
    logic [S*W-1:0] ed;
    @(negedge clk);
    rst_n = r; in_valid = iv; in_data = d; in_halt = ih;
    stall = st; flush = fl; flush_stage = fs;
    h = -1;
    hif = 0;
    for (int i = 0; i < S; i++) begin
      if (st[i]) h = i;
      if (mv[i] && mh[i]) hif = 1;
      ev[i] = mv[i];
      ed[i*W +: W] = md[i];
    end
    erdy = (h < 0) && !fl && !hif && !m_hlt;
    eov = mv[S-1] && !st[S-1];
    acc = iv && erdy;
    #1;
    pr_ready = in_ready; pr_ov = out_valid;
    pr_od = out_data; pr_sv = stage_valid;
    if (chk_on) begin
      check("stage_valid", stage_valid, ev);
      check("stage_data", stage_data, ed);
      check("in_ready", in_ready, erdy);
      check("out_valid", out_valid, eov);
      if (eov) check("out_data", out_data, md[S-1]);
      check("hlt", hlt, m_hlt);
      check("retire_cnt", retire_cnt, m_cnt);
    end
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else begin
      if (eov) begin
        m_cnt = m_cnt + 16'd1;
        if (mh[S-1]) m_hlt = 1;
      end
      if (fl) begin
        k = (int'(fs) > S - 2) ? S - 2 : int'(fs);
        for (int i = S - 1; i > 0; i--) begin
          mv[i] = mv[i-1]; mh[i] = mh[i-1]; md[i] = md[i-1];
        end
        mv[0] = 0; mh[0] = 0; md[0] = d;
        for (int i = 0; i <= k; i++) begin
          mv[i] = 0; mh[i] = 0;
        end
      end else begin
        for (int i = S - 1; i > h; i--) begin
          if (h >= 0 && i == h + 1) begin
            mv[i] = 0; mh[i] = 0;
          end else if (i == 0) begin
            mv[0] = acc; mh[0] = ih && acc; md[0] = d;
          end else begin
            mv[i] = mv[i-1]; mh[i] = mh[i-1]; md[i] = md[i-1];
          end
        end
      end
    end
    #1;
  endtask

  task automatic idle(input logic [S-1:0] st);
    step(1, 0, '0, 0, st, 0, '0);
  endtask

  task automatic do_reset();
    step(0, 0, '0, 0, '0, 0, '0);
    step(0, 0, '0, 0, '0, 0, '0);
  endtask

  task automatic fill_ea();
    logic [W-1:0] v;
    for (int i = 0; i < S; i++) begin
      v = 16'h000E - 16'(i);
      step(1, 1, v, 0, '0, 0, '0);
    end
  endtask

  initial begin
    int n;
    rst_n = 0; in_valid = 0; in_data = '0; in_halt = 0;
    stall = '0; flush = 0; flush_stage = '0;
    model_reset();
    do_reset();
    chk_on = 1;

    check("reset_valid", stage_valid, 5'b0);
    check("reset_data", stage_data, '0);
    check("reset_hlt", hlt, 1'b0);
    check("reset_cnt", retire_cnt, 16'd0);

    tbl[0] = '{1, 16'h0001, 5'b00000, 1, 0, 16'h0};
    tbl[1] = '{1, 16'h0002, 5'b00001, 1, 0, 16'h0};
    tbl[2] = '{1, 16'h0003, 5'b00011, 1, 0, 16'h0};
    tbl[3] = '{0, 16'h0000, 5'b00111, 1, 0, 16'h0};
    tbl[4] = '{0, 16'h0000, 5'b01110, 1, 0, 16'h0};
    tbl[5] = '{0, 16'h0000, 5'b11100, 1, 1, 16'h0001};
    tbl[6] = '{0, 16'h0000, 5'b11000, 1, 1, 16'h0002};
    tbl[7] = '{0, 16'h0000, 5'b10000, 1, 1, 16'h0003};
    tbl[8] = '{0, 16'h0000, 5'b00000, 1, 0, 16'h0};
    for (int i = 0; i < 9; i++) begin
      step(1, tbl[i].iv, tbl[i].d, 0, '0, 0, '0);
      check("tbl_valid", pr_sv, tbl[i].ev);
      check("tbl_ready", pr_ready, tbl[i].er);
      check("tbl_ov", pr_ov, tbl[i].eov);
      if (tbl[i].eov) check("tbl_od", pr_od, tbl[i].eod);
    end
    check("stream_cnt", retire_cnt, 16'd3);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 49) != 0,
           $urandom_range(0, 3) != 0,
           W'($urandom),
           $urandom_range(0, 15) == 0,
           S'($urandom & $urandom & $urandom),
           $urandom_range(0, 7) == 0,
           4'($urandom_range(0, 15)));
    end

    do_reset();
    fill_ea();
    step(1, 1, 16'h0055, 0, 5'b00100, 0, '0);
    check("stall_ready", pr_ready, 1'b0);
    check("stall_ov", pr_ov, 1'b1);
    check("stall_od", pr_od, 16'h000E);
    check("stall_valid", stage_valid, 5'b10111);
    check("stall_s0", sd(0), 16'h000A);
    check("stall_s1", sd(1), 16'h000B);
    check("stall_s2", sd(2), 16'h000C);
    check("stall_s4", sd(4), 16'h000D);
    check("stall_cnt", retire_cnt, 16'd1);

    do_reset();
    fill_ea();
    step(1, 1, 16'h0099, 0, 5'b00010, 1, 4'd2);
    check("flush_ready", pr_ready, 1'b0);
    check("flush_ov", pr_ov, 1'b1);
    check("flush_valid", stage_valid, 5'b11000);
    check("flush_s3", sd(3), 16'h000C);
    check("flush_s4", sd(4), 16'h000D);

    do_reset();
    step(1, 1, 16'h00FF, 1, '0, 0, '0);
    check("halt_acc", pr_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 16'h0011, 0, '0, 0, '0);
      check("halt_block", pr_ready, 1'b0);
    end
    step(1, 1, 16'h0011, 0, '0, 0, '0);
    check("halt_ov", pr_ov, 1'b1);
    check("halt_od", pr_od, 16'h00FF);
    check("halt_set", hlt, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 16'h0022, 0, '0, 0, '0);
      check("hlt_ready", pr_ready, 1'b0);
      check("hlt_sticky", hlt, 1'b1);
    end

    do_reset();
    step(1, 1, 16'h0077, 1, '0, 0, '0);
    idle('0);
    step(1, 1, 16'h0033, 0, '0, 1, 4'd2);
    check("fhalt_ready0", pr_ready, 1'b0);
    idle('0);
    check("fhalt_ready1", pr_ready, 1'b1);
    for (int i = 0; i < 6; i++) idle('0);
    check("fhalt_hlt", hlt, 1'b0);

    do_reset();
    chk_on = 0;
    n = 0;
    while (m_cnt != 16'hFFFF && n < 70000) begin
      step(1, 1, W'(n), 0, '0, 0, '0);
      n++;
    end
    chk_on = 1;
    check("wrap_reach", m_cnt, 16'hFFFF);
    check("cnt_ffff", retire_cnt, 16'hFFFF);
    step(1, 1, 16'h1234, 0, '0, 0, '0);
    check("cnt_wrap", retire_cnt, 16'h0000);

    step(1, 1, 16'h4321, 0, 5'b11111, 0, '0);
    check("full_stalled", pr_sv, 5'b11111);
    step(0, 1, 16'h4321, 0, 5'b11111, 0, '0);
    check("rst_valid", stage_valid, 5'b0);
    check("rst_hlt", hlt, 1'b0);
    check("rst_cnt", retire_cnt, 16'd0);
    idle('0);
    check("rst_ready", pr_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
